// File: rtl/mp_pkg.sv
// Shared definitions for the mp_top core and the instr_fetch stage in front of it.
// Contents:
//   - ALU opcode constants
//   - instruction field positions
//   - fetch FSM state enum
//   - opcode_legal(): true for an opcode the ALU implements
package mp_pkg;

    localparam int unsigned InstrW = 32;

    // Opcodes (shared with the ALU decoder)
    localparam logic [5:0] OpAdd = 6'd1;
    localparam logic [5:0] OpXor = 6'd2;
    localparam logic [5:0] OpOr  = 6'd3;
    localparam logic [5:0] OpMin = 6'd4;
    localparam logic [5:0] OpAnd = 6'd5;
    localparam logic [5:0] OpSub = 6'd6;
    localparam logic [5:0] OpMax = 6'd7;
    localparam logic [5:0] OpNeg = 6'd8;
    localparam logic [5:0] OpAvg = 6'd11;
    localparam logic [5:0] OpAbs = 6'd13;
    localparam logic [5:0] OpNot = 6'd15;

    // Instruction field positions
    localparam int unsigned OpcodeLsb = 0;
    localparam int unsigned OpcodeMsb = 5;
    localparam int unsigned Src1Lsb   = 6;
    localparam int unsigned Src1Msb   = 10;
    localparam int unsigned Src2Lsb   = 11;
    localparam int unsigned Src2Msb   = 15;
    localparam int unsigned DstLsb    = 16;
    localparam int unsigned DstMsb    = 20;
    localparam int unsigned RsvdLsb   = 21;
    localparam int unsigned RsvdMsb   = 31;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCheck,
        StOut,
        StDone
    } fetch_state_e;

    function automatic logic opcode_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OpAdd, OpXor, OpOr, OpMin, OpAnd, OpSub,
            OpMax, OpNeg, OpAvg, OpAbs, OpNot: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction handshake between the fetch stage and the core.
//   instr_out   : 32-bit instruction word
//   instr_valid : instr_out holds a word for the core
//   instr_ready : core accepts instr_out this cycle
// master = fetch stage (producer), slave = core (consumer).
interface instr_fetch_if;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output instr_out,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr_out,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/prog_mem.sv
// Program memory: DEPTH x 32, one synchronous write port, one registered read port.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address, sampled every cycle
//   rdata : word at raddr from the previous cycle
// Contents are deliberately not reset.
module prog_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the mp_top core.
// Walks pc through a writable program memory and offers each word over a valid/ready
// handshake. A run ends on an all-zero halt word or after the word at DEPTH-1.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a run from address 0 (honoured in idle/done only)
//   load_we/addr/data : program memory write (honoured while not busy)
//   instr           : instruction handshake (master side)
//   pc              : address of the next word to fetch
//   busy            : a run is in progress
//   done            : run finished, held until start or rst
//   drop_count      : words discarded by screening, saturating at 255
// Build option INSTR_CHECK_EN: drop words with an illegal opcode or non-zero bits
// [31:21] and count them; without it every non-zero word is forwarded and
// drop_count is 0.
module instr_fetch
    import mp_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    instr_fetch_if.master instr,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic [7:0]    drop_count
);

    fetch_state_e state_q, state_d;

    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   out_q, out_d;
    logic          valid_q, valid_d;
    // Word currently in OUT came from DEPTH-1, so acceptance ends the run.
    logic          last_q, last_d;

    logic          mem_we;
    logic [31:0]   rdata;
    logic          is_last;
    logic          screen_fail;

`ifdef INSTR_CHECK_EN
    logic [7:0] drop_q, drop_d;
    assign screen_fail = !opcode_legal(rdata[OpcodeMsb:OpcodeLsb]) ||
                         (rdata[RsvdMsb:RsvdLsb] != '0);
`else
    assign screen_fail = 1'b0;
`endif

    assign is_last = (pc_q == AW'(DEPTH - 1));

    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_q),
        .rdata (rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

`ifdef INSTR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end
`endif

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        out_d   = out_q;
        valid_d = valid_q;
        last_d  = last_q;
`ifdef INSTR_CHECK_EN
        drop_d  = drop_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
`ifdef INSTR_CHECK_EN
                    drop_d  = '0;
`endif
                end
            end
            StFetch: begin
                state_d = StCheck;
            end
            StCheck: begin
                if (rdata == '0) begin
                    state_d = StDone;
                end else if (screen_fail) begin
`ifdef INSTR_CHECK_EN
                    drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
`endif
                    pc_d    = pc_q + AW'(1);
                    state_d = is_last ? StDone : StFetch;
                end else begin
                    out_d   = rdata;
                    valid_d = 1'b1;
                    pc_d    = pc_q + AW'(1);
                    last_d  = is_last;
                    state_d = StOut;
                end
            end
            StOut: begin
                if (instr.instr_ready) begin
                    valid_d = 1'b0;
                    state_d = last_q ? StDone : StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy              = (state_q != StIdle) && (state_q != StDone);
        done              = (state_q == StDone);
        mem_we            = load_we && !busy;
        pc                = pc_q;
        instr.instr_out   = out_q;
        instr.instr_valid = valid_q;
`ifdef INSTR_CHECK_EN
        drop_count        = drop_q;
`else
        drop_count        = '0;
`endif
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (DEPTH = 16).
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic        load_we;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic [7:0]  drop_count;

    int checks;
    int errors;
    logic [31:0] got [$];

    instr_fetch_if bus ();

    instr_fetch #(
        .DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .instr      (bus),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        cycle();
        load_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // Start a run with ready held high; collect every delivered word until done.
    task automatic run_until_done(input string tag, input int budget);
        bit fin;
        fin = 1'b0;
        got.delete();
        bus.instr_ready = 1'b1;
        pulse_start();
        for (int n = 0; n < budget && !fin; n++) begin
            if (bus.instr_valid) got.push_back(bus.instr_out);
            if (done) fin = 1'b1;
            else cycle();
        end
        chk({tag, "_finished"}, {31'd0, fin}, 32'd1);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        start           = 1'b0;
        load_we         = 1'b0;
        load_addr       = '0;
        load_data       = '0;
        bus.instr_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_out", bus.instr_out, 32'd0);
        chk("rst_pc", {28'd0, pc}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_drop", {24'd0, drop_count}, 32'd0);

        // Single instruction then halt, exact latency
        load(4'd0, 32'h001F1141);
        load(4'd1, 32'h0000_0000);
        bus.instr_ready = 1'b1;
        pulse_start();                          // now FETCH
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_valid_fetch", {31'd0, bus.instr_valid}, 32'd0);
        cycle();                                // CHECK
        chk("t1_valid_check", {31'd0, bus.instr_valid}, 32'd0);
        cycle();                                // OUT
        chk("t1_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("t1_out", bus.instr_out, 32'h001F1141);
        chk("t1_pc_out", {28'd0, pc}, 32'd1);
        cycle();                                // accepted -> FETCH
        chk("t1_valid_drop", {31'd0, bus.instr_valid}, 32'd0);
        cycle();
        cycle();                                // halt word -> DONE
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_pc_done", {28'd0, pc}, 32'd1);
        chk("t1_busy_done", {31'd0, busy}, 32'd0);

        // Back-pressure; load and start together from DONE
        load(4'd1, 32'h001F1141);
        load(4'd2, 32'h0000_0000);
        bus.instr_ready = 1'b0;
        load_we   = 1'b1;
        load_addr = 4'd0;
        load_data = 32'h00150B82;
        pulse_start();
        load_we   = 1'b0;
        cycle();
        cycle();
        chk("t2_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("t2_out_new", bus.instr_out, 32'h00150B82);
        pulse_start();                          // ignored while busy
        chk("t2_start_busy_pc", {28'd0, pc}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t2_stall_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("t2_stall_out", bus.instr_out, 32'h00150B82);
        end
        bus.instr_ready = 1'b1;
        cycle();
        chk("t2_accept", {31'd0, bus.instr_valid}, 32'd0);
        bus.instr_ready = 1'b0;
        cycle();
        cycle();
        chk("t2_second_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("t2_second_out", bus.instr_out, 32'h001F1141);
        chk("t2_second_pc", {28'd0, pc}, 32'd2);
        bus.instr_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_pc_done", {28'd0, pc}, 32'd2);

        // Screening
        load(4'd0, 32'h0000_0009);
        load(4'd1, 32'h8000_0001);
        load(4'd2, 32'h00150B82);
        load(4'd3, 32'h0000_0000);
        run_until_done("t3", 40);
`ifdef INSTR_CHECK_EN
        chk("t3_count", got.size(), 32'd1);
        if (got.size() >= 1) chk("t3_word", got[0], 32'h00150B82);
        chk("t3_drop", {24'd0, drop_count}, 32'd2);
`else
        chk("t3_count", got.size(), 32'd3);
        if (got.size() == 3) begin
            chk("t3_word0", got[0], 32'h0000_0009);
            chk("t3_word1", got[1], 32'h8000_0001);
            chk("t3_word2", got[2], 32'h00150B82);
        end
        chk("t3_drop", {24'd0, drop_count}, 32'd0);
`endif
        chk("t3_pc", {28'd0, pc}, 32'd3);

        // End of memory: every word legal and non-zero
        for (int a = 0; a < 16; a++) load(4'(a), 32'h0000_0001);
        run_until_done("t4", 100);
        chk("t4_count", got.size(), 32'd16);
        chk("t4_pc", {28'd0, pc}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t4_no_extra_valid", {31'd0, bus.instr_valid}, 32'd0);
        end

        // Reset during OUT, then replay
        load(4'd0, 32'h001F1141);
        load(4'd1, 32'h00150B82);
        load(4'd2, 32'h0000_0000);
        bus.instr_ready = 1'b0;
        pulse_start();
        cycle();
        cycle();
        chk("t5_valid_pre", {31'd0, bus.instr_valid}, 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t5_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("t5_pc", {28'd0, pc}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        run_until_done("t5", 40);
        chk("t5_count", got.size(), 32'd2);
        if (got.size() == 2) begin
            chk("t5_word0", got[0], 32'h001F1141);
            chk("t5_word1", got[1], 32'h00150B82);
        end

        // Write during a run is ignored
        bus.instr_ready = 1'b1;
        pulse_start();
        load_we   = 1'b1;
        load_addr = 4'd1;
        load_data = 32'h0000_0003;
        cycle();
        load_we   = 1'b0;
        got.delete();
        for (int n = 0; n < 40 && !done; n++) begin
            if (bus.instr_valid) got.push_back(bus.instr_out);
            cycle();
        end
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_count", got.size(), 32'd2);
        if (got.size() == 2) chk("t6_word1", got[1], 32'h00150B82);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
